// File: rtl/rv_pkg.sv
// Shared TP-03 datapath definitions: opcode constants, the canonical NOP and
// the fetch-stage state encoding.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch redirect
// and the decode-side instruction handshake.
interface instr_fetch_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, branch_taken, branch_target,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, branch_taken, branch_target,
           inst_ready
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection: hold, sequential +4, or a
// word-aligned redirect (redirect wins).
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;
  logic        unused_target_lo;

  assign unused_target_lo = ^target_i[1:0];

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {target_i[31:2], 2'b00};
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding imem reads, registered
// instruction/PC toward decode, branch redirect with stale-response dropping.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
  input logic         clk,
  input logic         rst_n,
  instr_fetch_if.master fetch_io
);

  import rv_pkg::*;

  fetch_state_t state_q, state_d;
  logic         drop_q, drop_d;
  logic [31:0]  inst_q, inst_pc_q;
  logic [31:0]  pc;
  logic         pc_inc;
  logic         load_inst;
  logic         br;

  assign br = fetch_io.branch_taken;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (pc_inc),
    .redirect_i (br),
    .target_i   (fetch_io.branch_target),
    .pc_o       (pc)
  );

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    pc_inc    = 1'b0;
    load_inst = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (fetch_io.imem_req_ready) begin
          state_d = StWait;
          // A redirect that coincides with acceptance leaves a stale read in flight.
          drop_d  = br;
        end
      end
      StWait: begin
        if (fetch_io.imem_rsp_valid) begin
          drop_d = 1'b0;
          if (!br && !drop_q) begin
            load_inst = 1'b1;
            state_d   = StHold;
          end else begin
            state_d = StReq;
          end
        end else if (br) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (br) begin
          state_d = StReq;
        end else if (fetch_io.inst_ready) begin
          pc_inc  = 1'b1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      drop_q    <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (load_inst) begin
        inst_q    <= fetch_io.imem_rsp_data;
        inst_pc_q <= pc;
      end
    end
  end

  assign fetch_io.imem_req_valid = (state_q == StReq);
  assign fetch_io.imem_req_addr  = pc;
  assign fetch_io.inst_valid     = (state_q == StHold);
  assign fetch_io.inst_out       = inst_q;
  assign fetch_io.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory returns addr+1, the model tracks the
// next PC decode must see (sequential +4 or aligned branch target).
module tb_instr_fetch;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if fif ();
  instr_fetch_if fif1 ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst_n(rst_n), .fetch_io(fif));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst_n(rst1_n), .fetch_io(fif1));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          rise_cyc[$];
  logic [31:0] cur_pc = 32'h0;
  logic [31:0] held_out, held_pc;
  logic        prev_valid = 1'b0;

  int br_pct = 0, iready_pct = 100, mready_pct = 100, junk_pct = 0;
  int lat_min = 0, lat_max = 0;
  logic        br_now = 1'b0;
  logic [31:0] br_tgt = 32'h0;

  logic        pend_v = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a new instruction is presented whenever inst_valid rises.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (fif.inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected inst_pc=%h inst_out=%h required=no instruction",
                   fif.inst_pc, fif.inst_out);
        end else begin
          cur_pc = exp_q.pop_front();
          check("inst_pc", fif.inst_pc, cur_pc);
          check("inst_out", fif.inst_out, cur_pc + 32'd1);
        end
        held_out = fif.inst_out;
        held_pc  = fif.inst_pc;
        rise_cyc.push_back(cyc);
      end else if (fif.inst_valid) begin
        check("hold_out_stable", fif.inst_out, held_out);
        check("hold_pc_stable", fif.inst_pc, held_pc);
      end
      prev_valid = fif.inst_valid;
    end
  end

  // One clock: choose inputs from current outputs, update models, advance.
  task automatic step();
    logic        br, iready, mready, had_pend, rsp_v;
    logic [31:0] tgt, rsp_d;
    br  = 1'b0;
    tgt = $urandom;
    if (rst_n) begin
      if (br_now) begin
        br  = 1'b1;
        tgt = br_tgt;
      end else if ($urandom_range(99) < br_pct) begin
        br = 1'b1;
      end
    end
    br_now   = 1'b0;
    iready   = ($urandom_range(99) < iready_pct);
    mready   = ($urandom_range(99) < mready_pct);
    had_pend = pend_v;
    rsp_v    = 1'b0;
    rsp_d    = $urandom;
    if (pend_v) begin
      if (pend_lat == 0) begin
        rsp_v  = 1'b1;
        rsp_d  = pend_addr + 32'd1;
        pend_v = 1'b0;
      end else begin
        pend_lat--;
      end
    end else if ($urandom_range(99) < junk_pct) begin
      rsp_v = 1'b1;
    end
    if (rst_n) begin
      check("req_vs_hold_exclusive", 32'(fif.imem_req_valid && fif.inst_valid), 32'h0);
      if (fif.imem_req_valid && mready) begin
        check("one_outstanding", 32'(had_pend), 32'h0);
        check("req_aligned", 32'(fif.imem_req_addr[1:0]), 32'h0);
        pend_v    = 1'b1;
        pend_addr = fif.imem_req_addr;
        pend_lat  = $urandom_range(lat_max, lat_min);
      end
      if (br) begin
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
      end else if (fif.inst_valid && iready) begin
        exp_q.push_back(cur_pc + 32'd4);
      end
    end
    fif.branch_taken   = br;
    fif.branch_target  = tgt;
    fif.inst_ready     = iready;
    fif.imem_req_ready = mready;
    fif.imem_rsp_valid = rsp_v;
    fif.imem_rsp_data  = rsp_d;
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic until_req(input string name);
    int n = 0;
    while (!fif.imem_req_valid && n < 50) begin
      step();
      n++;
    end
    check(name, 32'(fif.imem_req_valid), 32'h1);
  endtask

  task automatic until_valid_pc(input string name, input logic [31:0] pc);
    int n = 0;
    while (!(fif.inst_valid && fif.inst_pc == pc) && n < 60) begin
      step();
      n++;
    end
    check(name, fif.inst_pc, pc);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  initial begin
    int          n;
    logic        p1, pv1;
    logic [31:0] p1a;
    logic [31:0] req1_q[$], pc1_q[$], out1_q[$];

    fif.branch_taken = 0; fif.branch_target = 0; fif.inst_ready = 0;
    fif.imem_req_ready = 0; fif.imem_rsp_valid = 0; fif.imem_rsp_data = 0;
    fif1.branch_taken = 0; fif1.branch_target = 0; fif1.inst_ready = 0;
    fif1.imem_req_ready = 0; fif1.imem_rsp_valid = 0; fif1.imem_rsp_data = 0;
    assert_reset();
    @(negedge clk);
    #1;
    repeat (3) step();

    // Reset values
    check("rst_req_valid", 32'(fif.imem_req_valid), 32'h0);
    check("rst_inst_valid", 32'(fif.inst_valid), 32'h0);
    check("rst_inst_out", fif.inst_out, 32'h0000_0013);
    check("rst_inst_pc", fif.inst_pc, 32'h0);
    check("rst_req_addr", fif.imem_req_addr, 32'h0);

    // First request lands in the 2nd cycle after release
    rst_n = 1'b1;
    check("first_cycle_no_req", 32'(fif.imem_req_valid), 32'h0);
    step();
    check("second_cycle_req", 32'(fif.imem_req_valid), 32'h1);
    check("first_req_addr", fif.imem_req_addr, 32'h0);

    // Straight-line fetch: one instruction per 3 cycles
    until_valid_pc("reach_pc8", 32'h8);
    check("rise_count", 32'(rise_cyc.size()), 32'd3);
    if (rise_cyc.size() >= 3) begin
      check("spacing_0_4", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
      check("spacing_4_8", 32'(rise_cyc[2] - rise_cyc[1]), 32'd3);
    end

    // Reset during WAIT, late response must be ignored
    until_req("req_after_8");
    check("req_addr_c", fif.imem_req_addr, 32'hC);
    lat_min = 6; lat_max = 6;
    step();
    step();
    assert_reset();
    mready_pct = 0;
    step();
    check("midrst_req_valid", 32'(fif.imem_req_valid), 32'h0);
    check("midrst_inst_valid", 32'(fif.inst_valid), 32'h0);
    step();
    rst_n = 1'b1;
    n = 0;
    while (pend_v && n < 20) begin
      step();
      n++;
    end
    check("late_rsp_delivered", 32'(pend_v), 32'h0);
    check("restart_addr", fif.imem_req_addr, 32'h0);
    mready_pct = 100; lat_min = 0; lat_max = 0;
    until_valid_pc("restart_pc0", 32'h0);
    check("restart_inst", fif.inst_out, 32'h1);

    // Downstream backpressure at pc 4
    until_valid_pc("reach_pc4", 32'h4);
    iready_pct = 0;
    repeat (5) begin
      step();
      check("stall_valid", 32'(fif.inst_valid), 32'h1);
      check("stall_out", fif.inst_out, 32'h5);
      check("stall_no_req", 32'(fif.imem_req_valid), 32'h0);
    end
    iready_pct = 100;

    // Redirect while waiting for the response to 8
    until_req("req_for_8");
    check("req_addr_8", fif.imem_req_addr, 32'h8);
    lat_min = 2; lat_max = 2;
    step();
    br_now = 1'b1; br_tgt = 32'h0000_0103;
    step();
    lat_min = 0; lat_max = 0;
    until_req("req_after_wait_redirect");
    check("redirect_wait_addr", fif.imem_req_addr, 32'h100);
    until_valid_pc("redirect_wait_pc", 32'h100);
    check("redirect_wait_inst", fif.inst_out, 32'h101);

    // Redirect in HOLD with inst_ready=1 in the same cycle
    br_now = 1'b1; br_tgt = 32'h40;
    step();
    check("hold_redirect_valid_drop", 32'(fif.inst_valid), 32'h0);
    until_req("req_after_hold_redirect");
    check("hold_redirect_addr", fif.imem_req_addr, 32'h40);
    until_valid_pc("hold_redirect_pc", 32'h40);

    // Randomised traffic
    br_pct = 6; iready_pct = 60; mready_pct = 70; junk_pct = 10; lat_min = 0; lat_max = 3;
    repeat (3000) step();
    br_pct = 0; junk_pct = 0; iready_pct = 100; mready_pct = 100;
    repeat (10) step();

    // Wrap-around on the second instance
    check("wrap_rst_pc", fif1.inst_pc, 32'hFFFF_FFFC);
    check("wrap_rst_out", fif1.inst_out, 32'h0000_0013);
    rst1_n = 1'b1;
    p1 = 1'b0; pv1 = 1'b0; p1a = 32'h0;
    repeat (12) begin
      if (fif1.imem_req_valid) req1_q.push_back(fif1.imem_req_addr);
      if (fif1.inst_valid && !pv1) begin
        pc1_q.push_back(fif1.inst_pc);
        out1_q.push_back(fif1.inst_out);
      end
      pv1 = fif1.inst_valid;
      fif1.imem_rsp_valid = p1;
      fif1.imem_rsp_data  = p1a + 32'd1;
      p1  = fif1.imem_req_valid;
      p1a = fif1.imem_req_addr;
      fif1.imem_req_ready = 1'b1;
      fif1.inst_ready     = 1'b1;
      @(negedge clk);
      #1;
    end
    check("wrap_req_count_ge2", 32'(req1_q.size() >= 2), 32'h1);
    check("wrap_inst_count_ge2", 32'(pc1_q.size() >= 2), 32'h1);
    if (req1_q.size() >= 2 && pc1_q.size() >= 2) begin
      check("wrap_req0", req1_q[0], 32'hFFFF_FFFC);
      check("wrap_req1", req1_q[1], 32'h0);
      check("wrap_pc0", pc1_q[0], 32'hFFFF_FFFC);
      check("wrap_out0", out1_q[0], 32'hFFFF_FFFD);
      check("wrap_pc1", pc1_q[1], 32'h0);
      check("wrap_out1", out1_q[1], 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout cycle=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
